// File: rtl/vr_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
//   state_e : fetch FSM states (RUN / HALT / FAULT)
//   entry_t : buffered {pc, inst} pair handed to decode
package vr_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  // Word returned by instruction memory past the end of the program.
  localparam logic [XLEN-1:0] INST_END = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

endpackage

// File: rtl/vr_fetch_skid.sv
// Two-entry FIFO of fetched {pc, inst} pairs, head-first shift organisation.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   push_i/entry_i : write an entry
//   pop_i          : consume the head
//   flush_i        : empty the FIFO (overrides push/pop)
//   count_o        : occupancy 0..2
//   head_valid_o   : head present; head_o reads 0 when empty
module vr_fetch_skid
  import vr_fetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  entry_t           entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             head_valid_o,
  output entry_t           head_o
);

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: pop shifts tail into head, push fills the first free slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_d = entry_i;
          else                 tail_d = entry_i;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = entry_i;
          end else begin
            head_d = entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_o       = head_valid_o ? head_q : '0;

endmodule

// File: rtl/vr_fetch_unit.sv
// Instruction fetch front end: PC register, fetch FSM, misalign flag and a
// two-entry buffer toward decode.
//   clk_i, rst_n_i      : clock, synchronous active-low reset
//   imem_addr_o         : fetch address (the PC register)
//   imem_inst_i         : instruction at imem_addr_o, same cycle
//   redirect_i/_pc_i    : branch/jump redirect from execute
//   out_valid_o/_ready_i: decode handshake; out_pc_o/out_inst_o head entry
//   halted_o            : fetch stopped (HALT or FAULT)
//   misalign_o          : sticky, a redirect target was not word aligned
module vr_fetch_unit
  import vr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_inst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_inst_o,
  output logic            halted_o,
  output logic            misalign_o
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;

  logic             push, pop, flush, fetch_en;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  entry_t           head;
  entry_t           new_entry;

  assign new_entry = '{pc: pc_q, inst: imem_inst_i};

  // A full buffer may still fetch when its head leaves this cycle.
  assign fetch_en = (state_q == ST_RUN) &&
                    ((count < 2'd2) || ((count == 2'd2) && out_ready_i));

  // Next-state: redirect outranks fetch/pop; FAULT ignores everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    push       = 1'b0;
    pop        = head_valid && out_ready_i;
    flush      = 1'b0;
    if (redirect_i && (state_q != ST_FAULT)) begin
      flush = 1'b1;
      pop   = 1'b0;
      if (redirect_pc_i[1:0] == 2'b00) begin
        pc_d    = redirect_pc_i;
        state_d = ST_RUN;
      end else begin
        misalign_d = 1'b1;
        state_d    = ST_FAULT;
      end
    end else if (fetch_en) begin
      if (imem_inst_i == INST_END) begin
        state_d = ST_HALT;
      end else begin
        push = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  vr_fetch_skid u_skid (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (push),
    .entry_i      (new_entry),
    .pop_i        (pop),
    .flush_i      (flush),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  assign imem_addr_o = pc_q;
  assign out_valid_o = head_valid;
  assign out_pc_o    = head.pc;
  assign out_inst_o  = head.inst;
  assign halted_o    = (state_q != ST_RUN);
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_vr_fetch_unit.sv
// Directed bench for vr_fetch_unit against a bubble-sort program image.
module tb_vr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        halted;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vr_fetch_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .imem_addr_o   (imem_addr),
    .imem_inst_i   (imem_inst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_inst_o    (out_inst),
    .halted_o      (halted),
    .misalign_o    (misalign)
  );

  // Program image: words at 0..80, zero everywhere else.
  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'd0:   prog = 32'h00400713;
      32'd4:   prog = 32'h00900593;
      32'd8:   prog = 32'h00259593;
      32'd12:  prog = 32'h00000613;
      32'd16:  prog = 32'h00c586b3;
      32'd20:  prog = 32'h0006a283;
      32'd24:  prog = 32'h0046a303;
      32'd28:  prog = 32'h006483b3;
      32'd32:  prog = 32'h0053d463;
      32'd36:  prog = 32'h0062a023;
      32'd40:  prog = 32'h0056a223;
      32'd44:  prog = 32'h00468693;
      32'd48:  prog = 32'hfeb6c6e3;
      32'd52:  prog = 32'h00160613;
      32'd56:  prog = 32'hfce64ae3;
      32'd60:  prog = 32'h00000013;
      32'd64:  prog = 32'h00470713;
      32'd68:  prog = 32'h40e585b3;
      32'd72:  prog = 32'h00058463;
      32'd76:  prog = 32'h00000613;
      32'd80:  prog = 32'hf8b2cce3;
      default: prog = 32'h00000000;
    endcase
  endfunction

  assign imem_inst = prog(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n_deliv;
    int cyc;
    int halt_cyc;
    logic [31:0] last_pc;
    logic [31:0] last_inst;

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_pc",       out_pc,         32'd0);
    chk("rst_inst",     out_inst,       32'd0);
    chk("rst_addr",     imem_addr,      32'd0);
    chk("rst_halted",   32'(halted),    32'd0);
    chk("rst_misalign", 32'(misalign),  32'd0);

    // Streaming with OUT_READY=1: one word per cycle
    step();
    chk("s0_valid", 32'(out_valid), 32'd1);
    chk("s0_pc",    out_pc,   32'd0);
    chk("s0_inst",  out_inst, 32'h00400713);
    step();
    chk("s1_pc",    out_pc,   32'd4);
    chk("s1_inst",  out_inst, 32'h00900593);
    step();
    chk("s2_pc",    out_pc,   32'd8);
    chk("s2_inst",  out_inst, 32'h00259593);

    // Backpressure: head and fetch address frozen
    do_reset();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_head",  out_pc,    32'd0);
      chk("bp_addr",  imem_addr, 32'd8);
    end
    out_ready = 1'b1;
    chk("bp_rel0", out_pc, 32'd0);
    step();
    chk("bp_rel1", out_pc, 32'd4);
    step();
    chk("bp_rel2", out_pc, 32'd8);
    chk("bp_rel2_inst", out_inst, 32'h00259593);

    // Redirect with a full buffer: one bubble, then target
    do_reset();
    step();
    out_ready = 1'b0;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'd28;
    step();
    redirect  = 1'b0;
    out_ready = 1'b1;
    chk("rd_bubble", 32'(out_valid), 32'd0);
    chk("rd_addr",   imem_addr, 32'd28);
    step();
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_pc",    out_pc,   32'd28);
    chk("rd_inst",  out_inst, 32'h006483b3);

    // Free run to end of program
    do_reset();
    n_deliv   = 0;
    halt_cyc  = -1;
    last_pc   = 32'hdead_beef;
    last_inst = 32'hdead_beef;
    cyc       = 0;
    while (cyc < 60 && !(halted && !out_valid)) begin
      step();
      cyc++;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (out_valid) begin
        n_deliv++;
        last_pc   = out_pc;
        last_inst = out_inst;
      end
    end
    chk("fr_timeout",  32'(cyc < 60),  32'd1);
    chk("fr_count",    32'(n_deliv),   32'd21);
    chk("fr_last_pc",  last_pc,        32'd80);
    chk("fr_last_ins", last_inst,      32'hf8b2cce3);
    chk("fr_halt_cyc", 32'(halt_cyc),  32'd22);
    chk("fr_halt_adr", imem_addr,      32'd84);
    step();
    chk("fr_drained",  32'(out_valid), 32'd0);
    chk("fr_halted",   32'(halted),    32'd1);

    // Redirect out of HALT
    redirect    = 1'b1;
    redirect_pc = 32'd0;
    step();
    redirect = 1'b0;
    chk("hr_halted", 32'(halted),    32'd0);
    chk("hr_valid",  32'(out_valid), 32'd0);
    step();
    chk("hr_pc",   out_pc,   32'd0);
    chk("hr_inst", out_inst, 32'h00400713);

    // Misaligned redirect: FAULT, PC holds at 4
    redirect    = 1'b1;
    redirect_pc = 32'd30;
    step();
    redirect = 1'b0;
    chk("ma_flag",   32'(misalign),  32'd1);
    chk("ma_halted", 32'(halted),    32'd1);
    chk("ma_valid",  32'(out_valid), 32'd0);
    chk("ma_addr",   imem_addr,      32'd4);
    step();
    step();
    chk("ma_nofetch", 32'(out_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'd0;
    step();
    redirect = 1'b0;
    chk("ma_ign_flag", 32'(misalign), 32'd1);
    chk("ma_ign_halt", 32'(halted),   32'd1);
    chk("ma_ign_addr", imem_addr,     32'd4);
    do_reset();
    chk("ma_rst_flag", 32'(misalign), 32'd0);
    chk("ma_rst_halt", 32'(halted),   32'd0);
    chk("ma_rst_addr", imem_addr,     32'd0);

    // Reset beats redirect with a full buffer
    out_ready = 1'b0;
    step();
    step();
    chk("rr_full", 32'(out_valid), 32'd1);
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'd28;
    step();
    rst_n    = 1'b1;
    redirect = 1'b0;
    chk("rr_valid",    32'(out_valid), 32'd0);
    chk("rr_addr",     imem_addr,      32'd0);
    chk("rr_misalign", 32'(misalign),  32'd0);
    chk("rr_halted",   32'(halted),    32'd0);
    chk("rr_pc",       out_pc,         32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
